// File: rtl/operand_src1_stage.sv
// Registered src1 operand select: Rn/Rs/PC/sign-extended immediate with EX/WB forwarding,
// load-use interlock and a one-entry valid/ready output register. Optional: SRC1_STALL_CNT_EN.
module operand_src1_stage #(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 4,
  parameter int PC_W      = 24,
  parameter int IMM_W     = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           sel,
  input  logic [REG_IDX_W-1:0] rn_idx,
  input  logic [REG_IDX_W-1:0] rs_idx,
  input  logic [DATA_W-1:0]    rn_data,
  input  logic [DATA_W-1:0]    rs_data,
  input  logic [PC_W-1:0]      pc,
  input  logic [IMM_W-1:0]     imm,
  input  logic                 ex_wr_en,
  input  logic [REG_IDX_W-1:0] ex_wr_idx,
  input  logic [DATA_W-1:0]    ex_wr_data,
  input  logic                 ex_is_load,
  input  logic                 wb_wr_en,
  input  logic [REG_IDX_W-1:0] wb_wr_idx,
  input  logic [DATA_W-1:0]    wb_wr_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    src1,
  output logic [1:0]           src1_fwd
`ifdef SRC1_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  localparam logic [1:0] SEL_RN   = 2'b00;
  localparam logic [1:0] SEL_RS   = 2'b01;
  localparam logic [1:0] SEL_PC   = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] v);
    return $signed({{(DATA_W-IMM_W){v[IMM_W-1]}}, v});
  endfunction

  function automatic logic signed [DATA_W-1:0] zext_pc(input logic [PC_W-1:0] v);
    return $signed({{(DATA_W-PC_W){1'b0}}, v});
  endfunction

  logic [REG_IDX_W-1:0]      idx_p0;
  logic signed [DATA_W-1:0]  rf_data_p0;
  logic signed [DATA_W-1:0]  data_p0;
  logic [1:0]                fwd_p0;
  logic                      is_reg_p0;
  logic                      ex_hit_p0;
  logic                      wb_hit_p0;
  logic                      hazard_p0;
  logic                      xfer_p0;

  logic signed [DATA_W-1:0]  src1_p1;
  logic [1:0]                fwd_p1;
  logic                      vld_p1;

  // p0: operand select, forwarding and load-use detection (combinational)
  always_comb begin
    idx_p0     = (sel == SEL_RS) ? rs_idx : rn_idx;
    rf_data_p0 = (sel == SEL_RS) ? $signed(rs_data) : $signed(rn_data);
    is_reg_p0  = !sel[1];
    ex_hit_p0  = ex_wr_en && (ex_wr_idx == idx_p0);
    wb_hit_p0  = wb_wr_en && (wb_wr_idx == idx_p0);
    // A pending load in EX is younger than anything in WB, so WB cannot cover it.
    hazard_p0  = is_reg_p0 && ex_hit_p0 && ex_is_load;
    data_p0    = rf_data_p0;
    fwd_p0     = FWD_NONE;
    case (sel)
      SEL_PC:  data_p0 = zext_pc(pc);
      SEL_IMM: data_p0 = sext_imm(imm);
      default: begin
        if (ex_hit_p0 && !ex_is_load) begin
          data_p0 = $signed(ex_wr_data);
          fwd_p0  = FWD_EX;
        end else if (wb_hit_p0) begin
          data_p0 = $signed(wb_wr_data);
          fwd_p0  = FWD_WB;
        end
      end
    endcase
  end

  assign in_ready = !hazard_p0 && (!vld_p1 || out_ready);
  assign xfer_p0  = in_valid && in_ready;

  // p1: output register; held data ignores later forwarding-bus activity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      src1_p1 <= '0;
      fwd_p1  <= FWD_NONE;
    end else if (flush) begin
      vld_p1  <= 1'b0;
    end else if (xfer_p0) begin
      vld_p1  <= 1'b1;
      src1_p1 <= data_p0;
      fwd_p1  <= fwd_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign src1      = src1_p1;
  assign src1_fwd  = fwd_p1;

`ifdef SRC1_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
